// File: rtl/ram_arb_pkg.sv
// Shared types for the work-RAM slot arbiter: access owner encoding and slot sizing.
// Owner codes double as the round-robin pointer value for the two fetch engines.
package ram_arb_pkg;
    localparam int SLOTS_DEF = 16;
    localparam int SLOT_W    = $clog2(SLOTS_DEF);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_SPR} owner_t;

    function automatic owner_t next_fetch(input owner_t cur);
        return (cur == OWN_VID) ? OWN_SPR : OWN_VID;
    endfunction
endpackage

// File: rtl/ram_slot_timer.sv
// Slot counter locked to the CPU cycle: a phi2 rising edge reloads slot 1, otherwise it free-runs.
// Slot is registered; cpu_slot is a decode of it, so both are valid from the start of the clk.
module ram_slot_timer #(
    parameter int SLOTS    = 16,
    parameter int CPU_SLOT = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       phi2,
    output logic [$clog2(SLOTS)-1:0]   slot,
    output logic                       cpu_slot
);
    import ram_arb_pkg::*;

    localparam int SW = $clog2(SLOTS);

    logic phi2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_d <= 1'b0;
            slot   <= '0;
        end else begin
            phi2_d <= phi2;
            // resync on phi2 rise takes priority over the natural wrap
            if (phi2 && !phi2_d)
                slot <= SW'(1);
            else
                slot <= slot + SW'(1);
        end
    end

    assign cpu_slot = (slot == SW'(CPU_SLOT));
endmodule

// File: rtl/ram_slot_arbiter.sv
// Shares one single-port sync RAM: fixed CPU slot, round-robin video/sprite elsewhere; read data 1 clk after grant.
// Requests are levels and simply wait when not granted; RAM_VID_PRIO_EN makes video win every contested slot.
module ram_slot_arbiter
    import ram_arb_pkg::*;
#(
    parameter int SLOTS    = SLOTS_DEF,
    parameter int CPU_SLOT = 10,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phi2,
    input  logic              cpu_clken,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_gnt,
    output logic              spr_valid,
    output logic [DATA_W-1:0] spr_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [$clog2(SLOTS)-1:0] slot;
    logic                     cpu_slot;
    owner_t                   owner, owner_d, rr_ptr;
    logic                     cpu_rd_d;
    logic [DATA_W-1:0]        cpu_rdata_q, vid_rdata_q, spr_rdata_q;
    logic                     unused;

    // slot timing comes from phi2 alone; the enable pulse carries no extra information here
    assign unused = ^{cpu_clken, slot};

    ram_slot_timer #(.SLOTS(SLOTS), .CPU_SLOT(CPU_SLOT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .phi2     (phi2),
        .slot     (slot),
        .cpu_slot (cpu_slot)
    );

    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            if (cpu_slot)                owner = OWN_CPU;
            else if (vid_req && spr_req) owner = rr_ptr;
            else if (vid_req)            owner = OWN_VID;
            else if (spr_req)            owner = OWN_SPR;
        end
    end

`ifdef RAM_VID_PRIO_EN
    assign rr_ptr = OWN_VID;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= OWN_VID;
        else if (!cpu_slot && vid_req && spr_req)
            rr_ptr <= next_fetch(rr_ptr);
    end
`endif

    always_comb begin
        mem_ce    = (owner != OWN_NONE);
        mem_we    = (owner == OWN_CPU) && cpu_we;
        mem_wdata = (owner == OWN_CPU) ? cpu_wdata : '0;
        case (owner)
            OWN_CPU: mem_addr = cpu_addr;
            OWN_VID: mem_addr = vid_addr;
            OWN_SPR: mem_addr = spr_addr;
            default: mem_addr = '0;
        endcase
    end

    assign vid_gnt = (owner == OWN_VID);
    assign spr_gnt = (owner == OWN_SPR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d     <= OWN_NONE;
            cpu_rd_d    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            spr_rdata_q <= '0;
        end else begin
            owner_d  <= owner;
            cpu_rd_d <= (owner == OWN_CPU) && !cpu_we;
            if (vid_valid)             vid_rdata_q <= mem_rdata;
            if (spr_valid)             spr_rdata_q <= mem_rdata;
            if ((owner_d == OWN_CPU) && cpu_rd_d) cpu_rdata_q <= mem_rdata;
        end
    end

    // RAM data is live in the return clk, so pass it straight through and hold it afterwards
    assign vid_valid = (owner_d == OWN_VID);
    assign spr_valid = (owner_d == OWN_SPR);
    assign vid_rdata = vid_valid ? mem_rdata : vid_rdata_q;
    assign spr_rdata = spr_valid ? mem_rdata : spr_rdata_q;
    assign cpu_rdata = ((owner_d == OWN_CPU) && cpu_rd_d) ? mem_rdata : cpu_rdata_q;
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Bench for ram_slot_arbiter: random and directed traffic against a per-clk behavioural model and a RAM model.
module tb_ram_slot_arbiter;
    localparam int NONE = 0, CPU = 1, VID = 2, SPR = 3;

    logic        clk = 1'b0;
    logic        rst, phi2, cpu_clken, cpu_we, vid_req, spr_req;
    logic [10:0] cpu_addr, vid_addr, spr_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, vid_rdata, spr_rdata, mem_wdata, mem_rdata;
    logic        vid_gnt, vid_valid, spr_gnt, spr_valid, mem_ce, mem_we;

    always #5 clk = ~clk;

    ram_slot_arbiter dut (
        .clk(clk), .rst(rst), .phi2(phi2), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_valid(vid_valid),
        .vid_rdata(vid_rdata),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_valid(spr_valid),
        .spr_rdata(spr_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'h15};
    endfunction

    // synchronous single-port RAM seen by the DUT
    bit [7:0] ram [2048];
    bit       ram_wr [2048];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // reference model state
    bit [7:0]   mmem [2048];
    bit         mwr  [2048];
    int         m_slot, m_rr, m_pend;
    bit         m_phi2_d, m_pend_rd;
    logic [7:0] m_pend_data, m_vrd, m_srd, m_crd;

    int checks = 0, passes = 0;
    int phase, vid_pct, spr_pct;
    bit stuck, cpu_rand, rst_mid;
    int cnt_vg, cnt_sg, cnt_ce;
    logic last_vgnt, last_vvld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] mread(input logic [10:0] a);
        return mwr[a] ? mmem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        m_slot = 0; m_phi2_d = 0; m_rr = 0; m_pend = NONE; m_pend_rd = 0;
        m_pend_data = '0; m_vrd = '0; m_srd = '0; m_crd = '0;
    endtask

    task automatic drive();
        if (!stuck) phase = (phase + 1) % 16;
        phi2      = (phase < 8);
        cpu_clken = (phase == 8);
        if (cpu_rand) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 11'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
        end
        vid_req  = ($urandom_range(0, 99) < vid_pct);
        spr_req  = ($urandom_range(0, 99) < spr_pct);
        vid_addr = 11'($urandom_range(0, 15));
        spr_addr = 11'($urandom_range(0, 15));
    endtask

    // check one clk at its negedge, then advance the model across the next posedge
    task automatic cycle();
        int          own;
        logic [10:0] a;
        @(negedge clk);
        own = NONE;
        if (!rst) begin
            if (m_slot == 10)            own = CPU;
            else if (vid_req && spr_req) own = (m_rr == 0) ? VID : SPR;
            else if (vid_req)            own = VID;
            else if (spr_req)            own = SPR;
        end
        a = (own == CPU) ? cpu_addr : (own == VID) ? vid_addr : (own == SPR) ? spr_addr : 11'd0;
        chk("mem_ce", mem_ce, own != NONE);
        chk("mem_we", mem_we, (own == CPU) && cpu_we);
        if (own != NONE) chk("mem_addr", mem_addr, a);
        if (own == CPU && cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
        chk("vid_gnt", vid_gnt, own == VID);
        chk("spr_gnt", spr_gnt, own == SPR);
        chk("vid_valid", vid_valid, !rst && m_pend == VID);
        chk("spr_valid", spr_valid, !rst && m_pend == SPR);
        chk("vid_rdata", vid_rdata, rst ? 8'd0 : (m_pend == VID) ? m_pend_data : m_vrd);
        chk("spr_rdata", spr_rdata, rst ? 8'd0 : (m_pend == SPR) ? m_pend_data : m_srd);
        chk("cpu_rdata", cpu_rdata, rst ? 8'd0 : (m_pend == CPU && m_pend_rd) ? m_pend_data : m_crd);
        last_vgnt = vid_gnt;
        last_vvld = vid_valid;
        cnt_vg += int'(vid_gnt);
        cnt_sg += int'(spr_gnt);
        cnt_ce += int'(mem_ce);
        if (rst_mid) rst = 1'b1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_pend == VID) m_vrd = m_pend_data;
            if (m_pend == SPR) m_srd = m_pend_data;
            if (m_pend == CPU && m_pend_rd) m_crd = m_pend_data;
            m_pend    = own;
            m_pend_rd = 0;
            if (own == CPU && cpu_we) begin
                mmem[cpu_addr] = cpu_wdata;
                mwr[cpu_addr]  = 1'b1;
            end else if (own != NONE) begin
                m_pend_data = mread(a);
                m_pend_rd   = 1'b1;
            end
`ifndef RAM_VID_PRIO_EN
            if (m_slot != 10 && vid_req && spr_req) m_rr = 1 - m_rr;
`endif
            m_slot   = (phi2 && !m_phi2_d) ? 1 : (m_slot + 1) % 16;
            m_phi2_d = phi2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            cycle();
        end
    endtask

    task automatic run_to_slot(input int s);
        for (int i = 0; i < 40 && m_slot != s; i++) begin
            drive();
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1; phi2 = 0; cpu_clken = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; spr_req = 0; vid_addr = '0; spr_addr = '0;
        phase = 0; stuck = 0; cpu_rand = 0; rst_mid = 0; vid_pct = 0; spr_pct = 0;
        cnt_vg = 0; cnt_sg = 0; cnt_ce = 0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;

        // idle fetchers: exactly one RAM access per CPU cycle
        run(16);
        cnt_ce = 0;
        run(16);
        chk("ce_per_cpu_cycle", cnt_ce, 1);

        // both fetchers saturated
        vid_pct = 100; spr_pct = 100;
        run(16);
        cnt_vg = 0; cnt_sg = 0;
        run(32);
        chk("grants_in_32", cnt_vg + cnt_sg, 30);
`ifdef RAM_VID_PRIO_EN
        chk("vid_grants_prio", cnt_vg, 30);
        chk("spr_grants_prio", cnt_sg, 0);
`else
        chk("vid_grants_rr", cnt_vg, 15);
        chk("spr_grants_rr", cnt_sg, 15);
`endif

        // CPU write then read-back with background fetch traffic
        vid_pct = 50; spr_pct = 50;
        cpu_addr = 11'h123; cpu_we = 1'b1; cpu_wdata = 8'h5A;
        run(16);
        cpu_we = 1'b0;
        run(16);
        chk("cpu_readback", cpu_rdata, 8'h5A);

        // request timing around the CPU slot
        vid_pct = 0; spr_pct = 0;
        run_to_slot(9);
        vid_pct = 100; drive(); cycle();
        chk("gnt_at_slot9", last_vgnt, 1);
        vid_pct = 0;
        run_to_slot(10);
        vid_pct = 100; drive(); cycle();
        chk("no_gnt_at_slot10", last_vgnt, 0);
        drive(); cycle();
        chk("gnt_at_slot11", last_vgnt, 1);
        vid_pct = 0; drive(); cycle();
        chk("valid_at_slot12", last_vvld, 1);

        // reset while a video read is in flight
        run_to_slot(3);
        vid_pct = 100; drive();
        rst_mid = 1'b1; cycle();
        rst_mid = 1'b0; vid_pct = 0;
        drive(); cycle();
        rst = 1'b0;
        drive(); cycle();
        chk("no_valid_after_rst", last_vvld, 0);
        run(4);

        // mixed random traffic, then phi2 stuck, then phase jumps forcing resyncs
        cpu_rand = 1; vid_pct = 60; spr_pct = 60;
        run(600);
        stuck = 1'b1;
        run(100);
        stuck = 1'b0;
        for (int k = 0; k < 8; k++) begin
            phase = $urandom_range(0, 15);
            run(37);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
